// File: rtl/hcpu_pkg.sv
// Shared definitions for the hiddenCPU sequencer: FSM state encoding and
// default sizing of the program counter.
package hcpu_pkg;

    typedef enum logic {
        SEQ_FETCH = 1'b0,
        SEQ_EXEC  = 1'b1
    } seq_state_e;

    localparam int          PC_W_DEF     = 8;
    localparam int unsigned RESET_PC_DEF = 32'd0;

endpackage

// File: rtl/branch_resolve.sv
// Combinational branch resolution for the sequencer: decides whether a
// branch is taken, computes the next program counter and gates the mov
// datapath so branch-class encodings never write a register.
module branch_resolve
    import hcpu_pkg::*;
#(
    parameter int PC_W = PC_W_DEF
) (
    input  logic            exec_i,
    input  logic            is_mov_op_i,
    input  logic            bcf_i,
    input  logic            bbf_i,
    input  logic            buc_i,
    input  logic            toggle_i,
    input  logic            carry_flag_i,
    input  logic            borrow_flag_i,
    input  logic [PC_W-1:0] pc_i,
    input  logic [7:0]      r3_i,
    output logic            taken_o,
    output logic            toggle_en_o,
    output logic [PC_W-1:0] pc_next_o,
    output logic            mov_en_o
);

    logic            sample_s;
    logic            strobe_any_s;
    logic [PC_W-1:0] offset_s;

    // Strobes only mean something while executing a mov/branch-class opcode.
    assign sample_s     = exec_i & is_mov_op_i;
    assign strobe_any_s = bcf_i | bbf_i | buc_i | toggle_i;
    assign offset_s     = PC_W'(r3_i);

    // Branch condition uses the flags registered before this execute cycle.
    assign taken_o     = sample_s & (buc_i | (bcf_i & carry_flag_i) | (bbf_i & borrow_flag_i));
    assign toggle_en_o = sample_s & toggle_i;
    assign mov_en_o    = sample_s & ~strobe_any_s;

    // Next PC: relative jump when taken (r3 = 0 spins), otherwise sequential.
    always_comb begin
        pc_next_o = pc_i;
        if (taken_o) begin
            pc_next_o = pc_i + offset_s;
        end else begin
            pc_next_o = pc_i + PC_W'(1);
        end
    end

endmodule

// File: rtl/branch_sequencer.sv
// Fetch/execute sequencer for the hiddenCPU core. Owns the program counter,
// carry/borrow flags and output-pin select; resolves branches from the
// mov/branch unit strobes. Optional return-address register is enabled by
// defining BRANCH_SEQ_LINK_REG_EN.
module branch_sequencer
    import hcpu_pkg::*;
#(
    parameter int          PC_W     = PC_W_DEF,
    parameter int unsigned RESET_PC = RESET_PC_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            instr_valid,
    output logic            instr_ready,
    input  logic            is_mov_op,
    input  logic            bcf,
    input  logic            bbf,
    input  logic            buc,
    input  logic            toggle_out,
    input  logic            alu_flag_we,
    input  logic            carry_in,
    input  logic            borrow_in,
    input  logic [7:0]      r3,
    output logic            mov_en,
`ifdef BRANCH_SEQ_LINK_REG_EN
    output logic [PC_W-1:0] link_pc,
`endif
    output logic [PC_W-1:0] pc,
    output logic            carry_flag,
    output logic            borrow_flag,
    output logic            out_sel,
    output logic            branch_taken
);

    seq_state_e      state_q;
    logic [PC_W-1:0] pc_q;
    logic            carry_q;
    logic            borrow_q;
    logic            out_sel_q;
    logic            branch_taken_q;

    logic            exec_s;
    logic            taken_s;
    logic            toggle_en_s;
    logic [PC_W-1:0] pc_d;

    assign exec_s = (state_q == SEQ_EXEC);

    branch_resolve #(
        .PC_W (PC_W)
    ) u_resolve (
        .exec_i        (exec_s),
        .is_mov_op_i   (is_mov_op),
        .bcf_i         (bcf),
        .bbf_i         (bbf),
        .buc_i         (buc),
        .toggle_i      (toggle_out),
        .carry_flag_i  (carry_q),
        .borrow_flag_i (borrow_q),
        .pc_i          (pc_q),
        .r3_i          (r3),
        .taken_o       (taken_s),
        .toggle_en_o   (toggle_en_s),
        .pc_next_o     (pc_d),
        .mov_en_o      (mov_en)
    );

`ifdef BRANCH_SEQ_LINK_REG_EN
    logic [PC_W-1:0] link_q;

    // Return address captured on every unconditional branch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            link_q <= '0;
        end else if (exec_s && is_mov_op && buc) begin
            link_q <= pc_q + PC_W'(1);
        end else begin
            link_q <= link_q;
        end
    end

    assign link_pc = link_q;
`endif

    // Two-state fetch/execute FSM with all architectural registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= SEQ_FETCH;
            pc_q           <= PC_W'(RESET_PC);
            carry_q        <= 1'b0;
            borrow_q       <= 1'b0;
            out_sel_q      <= 1'b0;
            branch_taken_q <= 1'b0;
        end else begin
            case (state_q)
                SEQ_FETCH: begin
                    branch_taken_q <= 1'b0;
                    if (instr_valid) begin
                        state_q <= SEQ_EXEC;
                    end else begin
                        state_q <= SEQ_FETCH;
                    end
                end
                SEQ_EXEC: begin
                    state_q        <= SEQ_FETCH;
                    pc_q           <= pc_d;
                    branch_taken_q <= taken_s;
                    if (alu_flag_we) begin
                        carry_q  <= carry_in;
                        borrow_q <= borrow_in;
                    end else begin
                        carry_q  <= carry_q;
                        borrow_q <= borrow_q;
                    end
                    if (toggle_en_s) begin
                        out_sel_q <= ~out_sel_q;
                    end else begin
                        out_sel_q <= out_sel_q;
                    end
                end
                default: begin
                    state_q        <= SEQ_FETCH;
                    branch_taken_q <= 1'b0;
                end
            endcase
        end
    end

    assign instr_ready  = (state_q == SEQ_FETCH);
    assign pc           = pc_q;
    assign carry_flag   = carry_q;
    assign borrow_flag  = borrow_q;
    assign out_sel      = out_sel_q;
    assign branch_taken = branch_taken_q;

endmodule

// File: doc/branch_sequencer.md
Name: branch_sequencer

Overview:
Fetch/execute sequencer for the hiddenCPU core that owns the program counter, carry/borrow flags and the output-pin select. It consumes the branch strobes decoded by the mov/branch unit (bcf, bbf, buc, toggle) and r3 to resolve branches. It also gates the mov datapath enable so that equal-address branch encodings never write a register. It sits between the instruction pin interface and the register file/ALU.

Parameters:
PC_W, 8, program counter width; branch offset is the low PC_W bits of r3.
RESET_PC, 0, PC value loaded on reset.

Ports:
clk  input  1  core clock, rising edge
rst  input  1  asynchronous active-high reset
instr_valid  input  1  external instruction present on pins
instr_ready  output  1  sequencer accepts an instruction this cycle
is_mov_op  input  1  decoded opcode is mov/branch class
bcf  input  1  branch-if-carry strobe from mov/branch unit
bbf  input  1  branch-if-borrow strobe
buc  input  1  unconditional branch strobe
toggle_out  input  1  output-select toggle strobe
alu_flag_we  input  1  ALU result valid; latch carry/borrow
carry_in  input  1  ALU carry out
borrow_in  input  1  ALU borrow out
r3  input  8  branch offset register
mov_en  output  1  enable to mov datapath (dOut gate)
pc  output  PC_W  program counter
carry_flag  output  1  registered carry
borrow_flag  output  1  registered borrow
out_sel  output  1  0 = pins show r3, 1 = pins show pc
branch_taken  output  1  one-cycle pulse, branch applied this EXEC

Behaviour:
- Reset (async, immediate): state=FETCH, pc=RESET_PC, carry_flag=0, borrow_flag=0, out_sel=0, branch_taken=0; instr_ready=1, mov_en=0 combinationally from state.
- FSM, two states:
  - FETCH: instr_ready=1, mov_en=0. On instr_valid=1, go to EXEC next edge; otherwise stay.
  - EXEC: instr_ready=0, always returns to FETCH next edge (single-cycle execute).
- Throughput: one instruction per 2 cycles. pc update visible the cycle after EXEC.
- Strobes sampled only in EXEC with is_mov_op=1; otherwise ignored.
- Any strobe in EXEC is a branch-class instruction, so mov_en=0 for it.
- mov_en=EXEC & is_mov_op & ~(bcf|bbf|buc|toggle_out).
- Branch condition taken = buc | (bcf & carry_flag) | (bbf & borrow_flag). Uses flag values registered before this EXEC, not the same-cycle carry_in/borrow_in.
- PC next in EXEC:
  - taken: pc + r3[PC_W-1:0], modulo 2^PC_W.
  - otherwise: pc + 1, modulo 2^PC_W.
  - r3=0 taken leaves pc unchanged (deliberate spin loop).
  - Wrap: pc=8'hFF +1 -> 8'h00; pc=8'hF0, r3=8'h20 -> 8'h10.
- branch_taken is registered: high for exactly one cycle after an EXEC with taken=1.
- toggle_out in EXEC flips out_sel; pc still advances by 1.
- Flags: when alu_flag_we=1 in EXEC, carry_flag<=carry_in and borrow_flag<=borrow_in. alu_flag_we is ignored in FETCH.
- Simultaneous flag write and branch: the branch decision uses the old flags, and the new flags latch at the same edge.
- Multiple strobes cannot be produced by the decoder. If they are, the taken expression above still applies, and toggle acts independently.
- Reset asserted mid-EXEC: instruction is abandoned, with no pc, flag or out_sel update.

Optional Feature:
Macro BRANCH_SEQ_LINK_REG_EN.
- Defined:
  - Adds output link_pc [PC_W-1:0], reset 0.
  - On a taken buc in EXEC, link_pc <= pc + 1 (return address).
  - Otherwise link_pc holds.
- Undefined: no link_pc port or register; behaviour otherwise identical.

Decomposition:
- Shared package hcpu_pkg: state encoding (SEQ_FETCH=1'b0, SEQ_EXEC=1'b1), PC_W default, RESET_PC default.
- One natural sub-module, branch_resolve: combinational; takes strobes, flags, pc and r3; produces taken, pc_next and mov_en.
- FSM and registers stay in branch_sequencer.

Test Plan:
- Reset released, instr_valid=1, is_mov_op=0, three instructions -> pc 0,1,2,3 after each EXEC; instr_ready toggles 1,0; mov_en stays 0.
- pc=5, EXEC with buc=1, r3=8'h10 -> pc=8'h15, branch_taken pulse one cycle, mov_en=0.
- carry_flag=0, EXEC with bcf=1 and alu_flag_we=1, carry_in=1 -> branch not taken (pc+1), carry_flag=1. Next bcf with r3=3 -> pc+3.
- pc=8'hFE, two plain EXECs -> 8'hFF then 8'h00. pc=8'hF0, bbf taken with r3=8'h20 -> 8'h10.
- toggle_out in EXEC twice -> out_sel 0->1->0, pc +1 each time; mov_en=0 in both EXECs.
- Plain mov, is_mov_op=1, no strobes -> mov_en=1 only during EXEC. Then assert rst during next EXEC -> pc=RESET_PC, flags 0, out_sel 0, state FETCH immediately.
